// File: rtl/md_pkg.sv
// Shared encodings and constants for the multiply/divide unit.
package md_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } md_state_e;

  // One result bit is produced per RUN cycle.
  localparam int unsigned ITER_COUNT = 32;

endpackage

// File: rtl/md_unit_if.sv
// Pipeline-side bundle of the multiply/divide unit: launch, MTHI/MTLO and HI/LO views.
interface md_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_A;
  logic [WIDTH-1:0] i_B;
  logic             i_mthi;
  logic             i_mtlo;
  logic [WIDTH-1:0] i_wdata;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (
    output i_start, i_op, i_A, i_B, i_mthi, i_mtlo, i_wdata,
    input  o_busy, o_done, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_A, i_B, i_mthi, i_mtlo, i_wdata,
    output o_busy, o_done, o_hi, o_lo
  );
endinterface

// File: rtl/md_iter_core.sv
// Unsigned bit-serial datapath: shift-add multiply or restoring shift-subtract divide.
module md_iter_core
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_last
);

  localparam int unsigned CntW = $clog2(ITER_COUNT);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  always_comb begin
    acc_d     = acc_q;
    sh_d      = sh_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : '0);
    div_shift = {acc_q, sh_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (i_load) begin
      acc_d = '0;
      sh_d  = i_a;
      b_d   = i_b;
      cnt_d = '0;
    end else if (i_step) begin
      cnt_d = cnt_q + 1'b1;
      if (i_is_div) begin
        // No borrow means the divisor fits: keep the difference, quotient bit 1.
        acc_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], ~div_diff[WIDTH]};
      end else begin
        acc_d = mul_sum[WIDTH:1];
        sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
      sh_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_hi   = acc_q;
  assign o_lo   = sh_q;
  assign o_last = (cnt_q == CntW'(ITER_COUNT - 1));

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: FSM, sign handling and architectural HI/LO registers.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  md_unit_if.slave bus
);

  md_state_e        state_q, state_d;
  logic             is_div_q, sign_a_q, sign_b_q, div_zero_q, done_q;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy, load, step, fix;
  logic             is_signed, a_neg, b_neg, neg_res;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] core_hi, core_lo, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod;
  logic             core_last;

  assign is_signed = (bus.i_op == OP_MULT) || (bus.i_op == OP_DIV);
  assign a_neg     = is_signed & bus.i_A[WIDTH-1];
  assign b_neg     = is_signed & bus.i_B[WIDTH-1];
  // The most negative value negates to itself, which reads as 2^(WIDTH-1) unsigned.
  assign a_mag     = a_neg ? -bus.i_A : bus.i_A;
  assign b_mag     = b_neg ? -bus.i_B : bus.i_B;
  assign neg_res   = sign_a_q ^ sign_b_q;

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (load),
    .i_step   (step),
    .i_is_div (is_div_q),
    .i_a      (a_mag),
    .i_b      (b_mag),
    .o_hi     (core_hi),
    .o_lo     (core_lo),
    .o_last   (core_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.i_start) state_d = ST_RUN;
      ST_RUN:  if (core_last) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    load = (state_q == ST_IDLE) && bus.i_start;
    step = (state_q == ST_RUN);
    fix  = (state_q == ST_FIX);
  end

  always_comb begin
    prod = {core_hi, core_lo};
    if (neg_res) prod = -prod;
    if (is_div_q) begin
      // Divide by zero leaves the remainder equal to the dividend; only LO is forced.
      res_lo = div_zero_q ? '1 : (neg_res ? -core_lo : core_lo);
      res_hi = sign_a_q ? -core_hi : core_hi;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (fix) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end else if ((state_q == ST_IDLE) && !bus.i_start) begin
      if (bus.i_mthi) hi_d = bus.i_wdata;
      if (bus.i_mtlo) lo_d = bus.i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      is_div_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      if (load) begin
        is_div_q   <= bus.i_op[1];
        sign_a_q   <= a_neg;
        sign_b_q   <= b_neg;
        div_zero_q <= (bus.i_B == '0);
      end
      done_q <= fix;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign bus.o_busy = busy;
  assign bus.o_done = done_q;
  assign bus.o_hi   = hi_q;
  assign bus.o_lo   = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit in the EX stage, beside the integer ALU.
- Executes MULT, MULTU, DIV and DIVU on the same A/B operands the ALU receives, then holds the results in architectural HI/LO registers.
- HI/LO feed the EX result mux for MFHI/MFLO. o_busy stalls the pipeline while an operation runs.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits. Only 32 is verified.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  launch an operation; sampled only in IDLE.
- i_op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- i_A  in  WIDTH  rs operand; dividend for DIV/DIVU.
- i_B  in  WIDTH  rt operand; divisor for DIV/DIVU.
- i_mthi  in  1  write i_wdata into HI.
- i_mtlo  in  1  write i_wdata into LO.
- i_wdata  in  WIDTH  MTHI/MTLO data.
- o_busy  out  1  operation in progress.
- o_done  out  1  one-cycle pulse when HI/LO have just been updated by an operation.
- o_hi  out  WIDTH  HI register.
- o_lo  out  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - State goes to IDLE; HI, LO and all internal registers clear to 0.
  - o_busy=0, o_done=0.
  - Any operation in flight is discarded.
- State machine: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - i_start=1 at edge E0 latches i_op and operand magnitudes. For signed ops, latch |A|, |B| and the result signs; 0x80000000 is treated as magnitude 2^31.
  - Clears the iteration counter and enters RUN.
- RUN: exactly 32 cycles, one bit per cycle.
  - Multiply: shift-add producing a 64-bit unsigned product.
  - Divide: restoring shift-subtract producing a 32-bit quotient and remainder.
- FIX: one cycle.
  - Apply sign correction: negate the product if signA^signB; negate the quotient if signA^signB; the remainder takes the sign of the dividend.
  - Write HI/LO and return to IDLE.
- Timing:
  - o_busy is 1 in cycles 1..33 after E0.
  - HI/LO update at edge E33.
  - o_done=1 during cycle 34 only, with o_busy=0 in that cycle.
  - Back-to-back: i_start may be asserted in the o_done cycle.
- Results:
  - MULT/MULTU: HI = upper 32 bits of the product, LO = lower 32 bits.
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero (i_B=0 at start): same 34-cycle latency; LO=0xFFFFFFFF, HI=i_A as latched. This applies to both DIV and DIVU.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- i_start while busy: ignored; the operation in flight continues.
- i_mthi/i_mtlo:
  - In IDLE: write the register at the next edge. Both may be asserted in the same cycle.
  - While busy: ignored.
  - In IDLE, if i_start and i_mthi/i_mtlo are asserted in the same cycle, i_start wins and the writes are dropped.
- o_hi/o_lo always show the register contents; they are stable during RUN.
- All arithmetic is modulo 2^WIDTH per half. No exceptions are raised.

Decomposition:
- Package md_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state enum (ST_IDLE, ST_RUN, ST_FIX), iteration count constant (32).
- One sub-module, md_iter_core: the per-cycle shift-add/shift-subtract datapath (accumulator, shift register, counter), controlled by the top-level FSM.
- Top level holds the FSM, sign handling, the HI/LO registers and the MTHI/MTLO logic.

Test Plan:
- Reset, then MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> o_done in cycle 34; HI=0xFFFFFFFE, LO=0x00000001; o_busy high for exactly 33 cycles.
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100 B=0 -> LO=0xFFFFFFFF, HI=100. Then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start DIVU 17/5, pulse i_start (op=MULTU) and i_mtlo at cycle 10 -> both ignored; final LO=3, HI=2. Then MTHI 0x1234 in IDLE -> o_hi=0x1234 next cycle.
- Start MULT, deassert i_rst_n asynchronously at cycle 15 -> o_busy, o_done, HI, LO all 0 immediately. After release, a new DIVU 9/3 -> LO=3, HI=0.
- i_start in the o_done cycle of a MULTU 2*3 -> HI=0, LO=6 remain visible for that cycle; the second operation (MULTU 4*5) completes 34 cycles later with LO=20.
